// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard sequencer: detects load-use and branch-operand hazards,
// drives bubble/write-enable controls, requests IF/ID flushes and counts events.
module hazard_stall_controller #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic             UsesRt,
    input  logic             IsBranch,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [REG_W-1:0] ID_EX_Dst,
    input  logic             EX_MEM_MemRead,
    input  logic [REG_W-1:0] EX_MEM_Dst,
    input  logic             BranchTaken,
    output logic             ControlMux,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             Stalling,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t           state_q;
    logic [1:0]       remaining_q;
    logic [CNT_W-1:0] stallCycles_q, stallCycles_d;
    logic [CNT_W-1:0] flushCount_q, flushCount_d;

    logic       exHit;
    logic       memHit;
    logic [1:0] need;
    logic       stallNow;
    logic       flushNow;

    // Later assignments override earlier ones, so the longest applicable stall wins.
    always_comb begin
        exHit  = (ID_EX_Dst != '0) &&
                 ((ID_EX_Dst == IF_ID_Rs) || (UsesRt && (ID_EX_Dst == IF_ID_Rt)));
        memHit = (EX_MEM_Dst != '0) &&
                 ((EX_MEM_Dst == IF_ID_Rs) || (UsesRt && (EX_MEM_Dst == IF_ID_Rt)));
        need = 2'd0;
        if (IsBranch && EX_MEM_MemRead && memHit)
            need = 2'd1;
        if (IsBranch && ID_EX_RegWrite && !ID_EX_MemRead && exHit)
            need = 2'd1;
        if (ID_EX_MemRead && exHit)
            need = IsBranch ? 2'd2 : 2'd1;
    end

    // Hazards are only looked at in IDLE; STALL holds the bubble unconditionally.
    always_comb begin
        stallNow = !Reset && ((state_q == STALL) || (need != 2'd0));
        flushNow = !Reset && BranchTaken && !stallNow;
    end

    always_comb begin
        stallCycles_d = stallCycles_q;
        flushCount_d  = flushCount_q;
        if (stallNow && (stallCycles_q != '1))
            stallCycles_d = stallCycles_q + 1'b1;
        if (flushNow && (flushCount_q != '1))
            flushCount_d = flushCount_q + 1'b1;
    end

    // remaining_q holds the bubbles still owed after the current one.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            remaining_q   <= 2'd0;
            stallCycles_q <= '0;
            flushCount_q  <= '0;
        end else begin
            stallCycles_q <= stallCycles_d;
            flushCount_q  <= flushCount_d;
            case (state_q)
                IDLE: begin
                    if (need != 2'd0) begin
                        remaining_q <= need - 2'd1;
                        state_q     <= (need > 2'd1) ? STALL : IDLE;
                    end
                end
                STALL: begin
                    remaining_q <= remaining_q - 2'd1;
                    if (remaining_q <= 2'd1)
                        state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    remaining_q <= 2'd0;
                end
            endcase
        end
    end

    assign ControlMux  = !Reset && !stallNow;
    assign PCWrite     = !Reset && !stallNow;
    assign IFIDWrite   = !Reset && !stallNow;
    assign IFIDFlush   = flushNow;
    assign Stalling    = stallNow;
    assign StallCycles = stallCycles_q;
    assign FlushCount  = flushCount_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: a bubble-debt model is compared
// against the DUT every cycle, with hand-computed expectations for the directed scenarios.
module tb_hazard_stall_controller;

    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic [REG_W-1:0] IF_ID_Rs = '0;
    logic [REG_W-1:0] IF_ID_Rt = '0;
    logic             UsesRt = 1'b0;
    logic             IsBranch = 1'b0;
    logic             ID_EX_MemRead = 1'b0;
    logic             ID_EX_RegWrite = 1'b0;
    logic [REG_W-1:0] ID_EX_Dst = '0;
    logic             EX_MEM_MemRead = 1'b0;
    logic [REG_W-1:0] EX_MEM_Dst = '0;
    logic             BranchTaken = 1'b0;
    logic             ControlMux, PCWrite, IFIDWrite, IFIDFlush, Stalling;
    logic [CNT_W-1:0] StallCycles, FlushCount;

    int checks = 0;
    int errors = 0;

    int owedBubbles = 0;
    int modelStalls = 0;
    int modelFlushes = 0;

    hazard_stall_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .UsesRt(UsesRt), .IsBranch(IsBranch),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_Dst(ID_EX_Dst),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_Dst(EX_MEM_Dst), .BranchTaken(BranchTaken),
        .ControlMux(ControlMux), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDFlush(IFIDFlush), .Stalling(Stalling),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    always #5 Clk = ~Clk;

    function automatic bit readsReg(input logic [REG_W-1:0] d);
        return (d != 0) && ((d == IF_ID_Rs) || (UsesRt && (d == IF_ID_Rt)));
    endfunction

    // Each rule proposes a bubble count; the largest proposal is the requirement.
    function automatic int requiredBubbles();
        int n = 0;
        if (IsBranch && ID_EX_MemRead && readsReg(ID_EX_Dst)) n = (n > 2) ? n : 2;
        if (ID_EX_MemRead && readsReg(ID_EX_Dst)) n = (n > 1) ? n : 1;
        if (IsBranch && ID_EX_RegWrite && !ID_EX_MemRead && readsReg(ID_EX_Dst)) n = (n > 1) ? n : 1;
        if (IsBranch && EX_MEM_MemRead && readsReg(EX_MEM_Dst)) n = (n > 1) ? n : 1;
        return n;
    endfunction

    function automatic bit modelStalling();
        return !Reset && ((owedBubbles > 0) || (requiredBubbles() > 0));
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owedBubbles  <= 0;
            modelStalls  <= 0;
            modelFlushes <= 0;
        end else if (owedBubbles > 0) begin
            owedBubbles <= owedBubbles - 1;
            modelStalls <= (modelStalls < CNT_MAX) ? modelStalls + 1 : CNT_MAX;
        end else if (requiredBubbles() > 0) begin
            owedBubbles <= requiredBubbles() - 1;
            modelStalls <= (modelStalls < CNT_MAX) ? modelStalls + 1 : CNT_MAX;
        end else if (BranchTaken) begin
            modelFlushes <= (modelFlushes < CNT_MAX) ? modelFlushes + 1 : CNT_MAX;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        bit st;
        st = modelStalling();
        checkOutput("model ControlMux", int'(ControlMux), int'(!Reset && !st));
        checkOutput("model PCWrite", int'(PCWrite), int'(!Reset && !st));
        checkOutput("model IFIDWrite", int'(IFIDWrite), int'(!Reset && !st));
        checkOutput("model IFIDFlush", int'(IFIDFlush), int'(!Reset && BranchTaken && !st));
        checkOutput("model Stalling", int'(Stalling), int'(st));
        checkOutput("model StallCycles", int'(StallCycles), modelStalls);
        checkOutput("model FlushCount", int'(FlushCount), modelFlushes);
    end

    task automatic applyStimulus(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                 input logic usesRt, input logic isBranch,
                                 input logic exMemRead, input logic exRegWrite,
                                 input logic [REG_W-1:0] exDst, input logic memMemRead,
                                 input logic [REG_W-1:0] memDst, input logic taken);
        @(posedge Clk);
        #1;
        IF_ID_Rs = rs; IF_ID_Rt = rt; UsesRt = usesRt; IsBranch = isBranch;
        ID_EX_MemRead = exMemRead; ID_EX_RegWrite = exRegWrite; ID_EX_Dst = exDst;
        EX_MEM_MemRead = memMemRead; EX_MEM_Dst = memDst; BranchTaken = taken;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 Reset = 1'b1;
        settle();
        checkOutput("reset ControlMux", int'(ControlMux), 0);
        checkOutput("reset StallCycles", int'(StallCycles), 0);
        checkOutput("reset IFIDFlush", int'(IFIDFlush), 0);
        @(posedge Clk); #1 Reset = 1'b0;
        settle();
        checkOutput("post-reset ControlMux", int'(ControlMux), 1);

        // Load-use: lw $8 in EX, add using $8 in ID.
        applyStimulus(8, 0, 0, 0, 1, 1, 8, 0, 0, 0);
        settle();
        checkOutput("loaduse ControlMux", int'(ControlMux), 0);
        checkOutput("loaduse PCWrite", int'(PCWrite), 0);
        applyStimulus(8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("loaduse released", int'(ControlMux), 1);
        checkOutput("loaduse StallCycles", int'(StallCycles), 1);

        // Register zero never hazards; rt ignored when not a source.
        applyStimulus(0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 1, 0, 1, 0, 0);
        settle();
        checkOutput("reg0 ControlMux", int'(ControlMux), 1);
        applyStimulus(3, 5, 0, 0, 1, 1, 5, 0, 0, 0);
        settle();
        checkOutput("unused rt Stalling", int'(Stalling), 0);

        // Branch on load in EX, then the load reaches MEM and costs one more bubble.
        applyStimulus(1, 9, 1, 1, 1, 1, 9, 0, 0, 0);
        applyStimulus(1, 9, 1, 1, 0, 0, 0, 1, 9, 0);
        settle();
        checkOutput("branch-load STALL", int'(Stalling), 1);
        applyStimulus(1, 9, 1, 1, 0, 0, 0, 1, 9, 0);
        settle();
        checkOutput("branch-memload Stalling", int'(Stalling), 1);
        applyStimulus(1, 9, 1, 1, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("branch-load done", int'(Stalling), 0);
        checkOutput("branch-load StallCycles", int'(StallCycles), 4);

        // Taken branch flushes without stalling; with a hazard the stall wins.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        settle();
        checkOutput("taken IFIDFlush", int'(IFIDFlush), 1);
        checkOutput("taken PCWrite", int'(PCWrite), 1);
        idleCycle();
        settle();
        checkOutput("taken FlushCount", int'(FlushCount), 1);
        applyStimulus(8, 0, 0, 0, 1, 1, 8, 0, 0, 1);
        settle();
        checkOutput("taken+hazard IFIDFlush", int'(IFIDFlush), 0);
        checkOutput("taken+hazard Stalling", int'(Stalling), 1);
        idleCycle();
        settle();
        checkOutput("taken+hazard FlushCount", int'(FlushCount), 1);
        checkOutput("taken+hazard StallCycles", int'(StallCycles), 5);

        // Branch on an ALU result still in EX.
        applyStimulus(4, 0, 0, 1, 0, 1, 4, 0, 0, 0);
        idleCycle();
        settle();
        checkOutput("branch-alu StallCycles", int'(StallCycles), 6);

        // Reset during the second bubble of a two-cycle stall.
        applyStimulus(1, 9, 1, 1, 1, 1, 9, 0, 0, 0);
        applyStimulus(1, 9, 1, 1, 0, 0, 0, 0, 0, 0);
        #2 Reset = 1'b1;
        settle();
        checkOutput("midstall reset StallCycles", int'(StallCycles), 0);
        checkOutput("midstall reset ControlMux", int'(ControlMux), 0);
        checkOutput("midstall reset Stalling", int'(Stalling), 0);
        idleCycle();
        Reset = 1'b0;
        settle();
        checkOutput("after reset ControlMux", int'(ControlMux), 1);

        // Saturation: twenty back-to-back load-use bubbles on a 4-bit counter.
        for (int i = 0; i < 20; i++)
            applyStimulus(8, 0, 0, 0, 1, 1, 8, 0, 0, 0);
        idleCycle();
        settle();
        checkOutput("saturated StallCycles", int'(StallCycles), 15);

        idleCycle();
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
